snake_engine: RTL and testbench

Parametrised single-clock successor to the snake game controller. Holds the snake body as a shift register of up to MAX_LEN cells with a runtime length counter, moves it on each GAME_TICK, grows it on apple capture, detects self-collision, places new apples off-body by rejection sampling, and renders the playfield to COLOUR one cycle after each pixel address. Sits between the master/navigation state machines, the LFSR random source and the VGA timing generator.

---
 rtl/snake_pkg.sv | 38 +++
 rtl/snake_cell_match.sv | 22 ++
 rtl/snake_engine.sv | 243 ++++++++++++++++++++++++
 tb/tb_snake_engine.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared types for the snake engine: directions, FSM states, grid cells and palette.
package snake_pkg;

    localparam int unsigned CELL_HW = 10;
    localparam int unsigned CELL_VW = 9;
    localparam int unsigned LEN_W   = 7;

    typedef enum logic [1:0] {
        DIR_RIGHT = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_UP    = 2'd2,
        DIR_LEFT  = 2'd3
    } dir_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PLACE = 2'd2,
        ST_DEAD  = 2'd3
    } state_e;

    // Cell coordinates are sized for the largest grid a 10x9-bit pixel address can reach.
    typedef struct packed {
        logic [CELL_HW-1:0] h;
        logic [CELL_VW-1:0] v;
    } cell_t;

    localparam logic [7:0] COL_APPLE = 8'h07;
    localparam logic [7:0] COL_SNAKE = 8'hFF;
    localparam logic [7:0] COL_BG    = 8'h40;
    localparam logic [7:0] COL_OFF   = 8'h00;

    // The encoding makes the opposite direction the bitwise complement.
    function automatic dir_e dir_opposite(input dir_e d);
        return dir_e'(~d);
    endfunction

endpackage

// File: rtl/snake_cell_match.sv
// Reports whether a query cell coincides with any body segment whose index is below limit_i.
module snake_cell_match
    import snake_pkg::*;
#(
    parameter int unsigned MAX_LEN = 15
) (
    input  cell_t [MAX_LEN-1:0] body_i,
    input  logic  [LEN_W-1:0]   limit_i,
    input  cell_t               query_i,
    output logic                hit_c_o
);

    always_comb begin
        hit_c_o = 1'b0;
        for (int unsigned i = 0; i < MAX_LEN; i++) begin
            if ((LEN_W'(i) < limit_i) && (body_i[i] == query_i)) begin
                hit_c_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/snake_engine.sv
// Snake game core: body shift register, move/grow/collide FSM, apple placement and cell renderer.
// Define SNAKE_WRAP_EN to wrap the head around the grid edges instead of dying at the walls.
module snake_engine
    import snake_pkg::*;
#(
    parameter int unsigned MAX_LEN   = 15,
    parameter int unsigned START_LEN = 5,
    parameter int unsigned GRID_W    = 80,
    parameter int unsigned GRID_H    = 60,
    parameter int unsigned CELL_BITS = 3,
    parameter int unsigned H_BITS    = 7,
    parameter int unsigned V_BITS    = 6
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              GAME_TICK,
    input  logic [1:0]        MASTER_STATE,
    input  logic [1:0]        NAVIGATION_STATE,
    input  logic [H_BITS-1:0] RAND_ADDRH,
    input  logic [V_BITS-1:0] RAND_ADDRV,
    input  logic [9:0]        ADDRH,
    input  logic [8:0]        ADDRV,
    output logic [7:0]        COLOUR,
    output logic              REACHED_TARGET,
    output logic              GAME_OVER,
    output logic [6:0]        SNAKE_LEN
);

    typedef cell_t [MAX_LEN-1:0] body_t;

    localparam logic [CELL_HW-1:0] GRID_W_C    = CELL_HW'(GRID_W);
    localparam logic [CELL_VW-1:0] GRID_H_C    = CELL_VW'(GRID_H);
    localparam logic [CELL_HW-1:0] H_MAX       = CELL_HW'(GRID_W - 1);
    localparam logic [CELL_VW-1:0] V_MAX       = CELL_VW'(GRID_H - 1);
    localparam logic [LEN_W-1:0]   MAX_LEN_C   = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0]   START_LEN_C = LEN_W'(START_LEN);
    localparam cell_t              APPLE_INIT  = '{h: CELL_HW'(GRID_W / 2), v: CELL_VW'(GRID_H / 2)};

    // Starting body lies along row 0 with the head at the right-hand end.
    function automatic body_t init_body();
        body_t b;
        for (int unsigned i = 0; i < MAX_LEN; i++) begin
            b[i].h = (i < START_LEN) ? CELL_HW'(START_LEN - 1 - i) : '0;
            b[i].v = '0;
        end
        return b;
    endfunction

    state_e            state_q, state_d;
    dir_e              dir_q, dir_d, dir_next_c;
    body_t             body_q, body_d;
    logic [LEN_W-1:0]  len_q, len_d, coll_limit_c;
    cell_t             apple_q, apple_d, next_head_c, cand_c, pix_c;
    logic [7:0]        colour_q, colour_d, render_c;
    logic              reached_q, reached_d, over_q, over_d;
    logic              tick_c, wall_c, eat_c, self_hit_c, place_hit_c, pix_hit_c;
    logic              cand_ok_c, pix_in_grid_c;

    assign tick_c = GAME_TICK && (MASTER_STATE == 2'd1);

    // A request to reverse onto the neck is ignored.
    always_comb begin
        dir_next_c = dir_e'(NAVIGATION_STATE);
        if (dir_next_c == dir_opposite(dir_q)) begin
            dir_next_c = dir_q;
        end
    end

    always_comb begin
        next_head_c = body_q[0];
        wall_c      = 1'b0;
        unique case (dir_next_c)
            DIR_RIGHT: begin
                if (body_q[0].h == H_MAX) begin
`ifdef SNAKE_WRAP_EN
                    next_head_c.h = '0;
`else
                    wall_c = 1'b1;
`endif
                end else begin
                    next_head_c.h = body_q[0].h + CELL_HW'(1);
                end
            end
            DIR_LEFT: begin
                if (body_q[0].h == '0) begin
`ifdef SNAKE_WRAP_EN
                    next_head_c.h = H_MAX;
`else
                    wall_c = 1'b1;
`endif
                end else begin
                    next_head_c.h = body_q[0].h - CELL_HW'(1);
                end
            end
            DIR_DOWN: begin
                if (body_q[0].v == V_MAX) begin
`ifdef SNAKE_WRAP_EN
                    next_head_c.v = '0;
`else
                    wall_c = 1'b1;
`endif
                end else begin
                    next_head_c.v = body_q[0].v + CELL_VW'(1);
                end
            end
            DIR_UP: begin
                if (body_q[0].v == '0) begin
`ifdef SNAKE_WRAP_EN
                    next_head_c.v = V_MAX;
`else
                    wall_c = 1'b1;
`endif
                end else begin
                    next_head_c.v = body_q[0].v - CELL_VW'(1);
                end
            end
        endcase
    end

    // The tail vacates its cell on a plain move, but stays put when the snake eats.
    assign eat_c        = (next_head_c == apple_q);
    assign coll_limit_c = eat_c ? len_q : (len_q - LEN_W'(1));

    assign cand_c    = '{h: CELL_HW'(RAND_ADDRH), v: CELL_VW'(RAND_ADDRV)};
    assign cand_ok_c = (cand_c.h < GRID_W_C) && (cand_c.v < GRID_H_C) && !place_hit_c;

    assign pix_c         = '{h: CELL_HW'(ADDRH >> CELL_BITS), v: CELL_VW'(ADDRV >> CELL_BITS)};
    assign pix_in_grid_c = (pix_c.h < GRID_W_C) && (pix_c.v < GRID_H_C);

    snake_cell_match #(.MAX_LEN(MAX_LEN)) u_collide (
        .body_i  (body_q),
        .limit_i (coll_limit_c),
        .query_i (next_head_c),
        .hit_c_o (self_hit_c)
    );

    snake_cell_match #(.MAX_LEN(MAX_LEN)) u_place (
        .body_i  (body_q),
        .limit_i (len_q),
        .query_i (cand_c),
        .hit_c_o (place_hit_c)
    );

    snake_cell_match #(.MAX_LEN(MAX_LEN)) u_render (
        .body_i  (body_q),
        .limit_i (len_q),
        .query_i (pix_c),
        .hit_c_o (pix_hit_c)
    );

    always_comb begin
        render_c = COL_BG;
        if (!pix_in_grid_c) begin
            render_c = COL_OFF;
        end else if (pix_c == apple_q) begin
            render_c = COL_APPLE;
        end else if (pix_hit_c) begin
            render_c = COL_SNAKE;
        end
    end

    // Next-state and output logic; reinit overrides everything, including a same-cycle tick.
    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        body_d    = body_q;
        len_d     = len_q;
        apple_d   = apple_q;
        reached_d = 1'b0;
        colour_d  = render_c;

        if (MASTER_STATE == 2'd0) begin
            state_d  = ST_IDLE;
            dir_d    = DIR_RIGHT;
            body_d   = init_body();
            len_d    = START_LEN_C;
            apple_d  = APPLE_INIT;
            colour_d = COL_OFF;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (MASTER_STATE == 2'd1) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (tick_c) begin
                        dir_d = dir_next_c;
                        if (wall_c || self_hit_c) begin
                            state_d = ST_DEAD;
                        end else begin
                            body_d = {body_q[MAX_LEN-2:0], next_head_c};
                            if (eat_c) begin
                                len_d     = (len_q == MAX_LEN_C) ? len_q : (len_q + LEN_W'(1));
                                reached_d = 1'b1;
                                state_d   = ST_PLACE;
                            end
                        end
                    end
                end
                ST_PLACE: begin
                    if (cand_ok_c) begin
                        apple_d = cand_c;
                        state_d = ST_RUN;
                    end
                end
                ST_DEAD: begin
                    state_d = ST_DEAD;
                end
            endcase
        end

        over_d = (state_d == ST_DEAD);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            dir_q     <= DIR_RIGHT;
            body_q    <= init_body();
            len_q     <= START_LEN_C;
            apple_q   <= APPLE_INIT;
            colour_q  <= COL_OFF;
            reached_q <= 1'b0;
            over_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            body_q    <= body_d;
            len_q     <= len_d;
            apple_q   <= apple_d;
            colour_q  <= colour_d;
            reached_q <= reached_d;
            over_q    <= over_d;
        end
    end

    assign COLOUR         = colour_q;
    assign REACHED_TARGET = reached_q;
    assign GAME_OVER      = over_q;
    assign SNAKE_LEN      = 7'(len_q);

endmodule

// File: tb/tb_snake_engine.sv
// Self-checking bench for snake_engine: directed scenarios plus randomized play against a queue-based game model.
module tb_snake_engine;

    localparam int MAX_LEN   = 15;
    localparam int START_LEN = 5;
    localparam int GRID_W    = 80;
    localparam int GRID_H    = 60;
    localparam int CELL_BITS = 3;
    localparam int H_BITS    = 7;
    localparam int V_BITS    = 6;

    logic              CLK = 1'b0;
    logic              RESET;
    logic              GAME_TICK;
    logic [1:0]        MASTER_STATE;
    logic [1:0]        NAVIGATION_STATE;
    logic [H_BITS-1:0] RAND_ADDRH;
    logic [V_BITS-1:0] RAND_ADDRV;
    logic [9:0]        ADDRH;
    logic [8:0]        ADDRV;
    logic [7:0]        COLOUR;
    logic              REACHED_TARGET;
    logic              GAME_OVER;
    logic [6:0]        SNAKE_LEN;

    int checks;
    int errors;

    // Game model: body as a queue of cells (head first) plus a few flags.
    int   mh[$];
    int   mv[$];
    int   m_dir;
    int   m_ah, m_av;
    bit   m_started, m_placing, m_dead, m_reach;
    logic [7:0] exp_col;

    snake_engine #(
        .MAX_LEN(MAX_LEN), .START_LEN(START_LEN), .GRID_W(GRID_W), .GRID_H(GRID_H),
        .CELL_BITS(CELL_BITS), .H_BITS(H_BITS), .V_BITS(V_BITS)
    ) dut (
        .CLK              (CLK),
        .RESET            (RESET),
        .GAME_TICK        (GAME_TICK),
        .MASTER_STATE     (MASTER_STATE),
        .NAVIGATION_STATE (NAVIGATION_STATE),
        .RAND_ADDRH       (RAND_ADDRH),
        .RAND_ADDRV       (RAND_ADDRV),
        .ADDRH            (ADDRH),
        .ADDRV            (ADDRV),
        .COLOUR           (COLOUR),
        .REACHED_TARGET   (REACHED_TARGET),
        .GAME_OVER        (GAME_OVER),
        .SNAKE_LEN        (SNAKE_LEN)
    );

    always #5 CLK = ~CLK;

    task automatic model_reinit();
        mh.delete();
        mv.delete();
        for (int i = 0; i < START_LEN; i++) begin
            mh.push_back(START_LEN - 1 - i);
            mv.push_back(0);
        end
        m_dir     = 0;
        m_ah      = GRID_W / 2;
        m_av      = GRID_H / 2;
        m_started = 0;
        m_placing = 0;
        m_dead    = 0;
        m_reach   = 0;
    endtask

    function automatic bit on_body(int h, int v, int upto);
        for (int i = 0; i < upto; i++) begin
            if (mh[i] == h && mv[i] == v) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [7:0] render(int px, int py);
        int ch, cv;
        ch = px >> CELL_BITS;
        cv = py >> CELL_BITS;
        if (ch >= GRID_W || cv >= GRID_H) return 8'h00;
        if (ch == m_ah && cv == m_av) return 8'h07;
        if (on_body(ch, cv, mh.size())) return 8'hFF;
        return 8'h40;
    endfunction

    function automatic int pxof(int c);
        return c * (1 << CELL_BITS) + int'($urandom_range(0, (1 << CELL_BITS) - 1));
    endfunction

    // Game rules applied at one clock edge.
    task automatic model_edge(int ms, bit tick, int nav, int rh, int rv);
        int dh [4] = '{1, 0, 0, -1};
        int dv [4] = '{0, 1, -1, 0};
        int nd, nh, nv;
        bit wall, eat, hit;
        m_reach = 0;
        if (ms == 0) begin
            model_reinit();
        end else if (m_dead) begin
        end else if (!m_started) begin
            if (ms == 1) m_started = 1;
        end else if (m_placing) begin
            rh = rh % (1 << H_BITS);
            rv = rv % (1 << V_BITS);
            if (rh < GRID_W && rv < GRID_H && !on_body(rh, rv, mh.size())) begin
                m_ah      = rh;
                m_av      = rv;
                m_placing = 0;
            end
        end else if (ms == 1 && tick) begin
            nd    = (nav == 3 - m_dir) ? m_dir : nav;
            m_dir = nd;
            nh    = mh[0] + dh[nd];
            nv    = mv[0] + dv[nd];
            wall  = 0;
            if (nh < 0 || nh >= GRID_W || nv < 0 || nv >= GRID_H) begin
`ifdef SNAKE_WRAP_EN
                nh = (nh + GRID_W) % GRID_W;
                nv = (nv + GRID_H) % GRID_H;
`else
                wall = 1;
`endif
            end
            eat = (nh == m_ah && nv == m_av);
            hit = on_body(nh, nv, eat ? mh.size() : mh.size() - 1);
            if (wall || hit) begin
                m_dead = 1;
            end else begin
                mh.push_front(nh);
                mv.push_front(nv);
                if (!eat || mh.size() > MAX_LEN) begin
                    void'(mh.pop_back());
                    void'(mv.pop_back());
                end
                if (eat) begin
                    m_reach   = 1;
                    m_placing = 1;
                end
            end
        end
    endtask

    // One clock: drive inputs just after an edge, advance the model at the next edge, return 1 time unit later.
    task automatic drive(int ms, bit tick, int nav, int rh, int rv, int px, int py);
        MASTER_STATE     = 2'(ms);
        GAME_TICK        = tick;
        NAVIGATION_STATE = 2'(nav);
        RAND_ADDRH       = H_BITS'(rh);
        RAND_ADDRV       = V_BITS'(rv);
        ADDRH            = 10'(px);
        ADDRV            = 9'(py);
        exp_col          = (ms == 0) ? 8'h00 : render(px, py);
        @(posedge CLK);
        model_edge(ms, tick, nav, rh, rv);
        #1;
        GAME_TICK = 1'b0;
    endtask

    task automatic test_reset();
        int ch [5] = '{4, 5, 40, 87, 10};
        int cv [5] = '{0, 0, 30, 2, 60};
        logic [7:0] want [5] = '{8'hFF, 8'h40, 8'h07, 8'h00, 8'h00};
        RESET = 1'b1;
        GAME_TICK = 1'b0; MASTER_STATE = 2'd1; NAVIGATION_STATE = 2'd0;
        RAND_ADDRH = '0; RAND_ADDRV = '0; ADDRH = '0; ADDRV = '0;
        #12;
        checks++;
        if (COLOUR !== 8'h00 || REACHED_TARGET !== 1'b0 || GAME_OVER !== 1'b0 || SNAKE_LEN !== 7'd5) begin
            errors++;
            $display("FAIL reset_outputs: got col=%h rt=%b go=%b len=%0d expected col=00 rt=0 go=0 len=5",
                     COLOUR, REACHED_TARGET, GAME_OVER, SNAKE_LEN);
        end
        @(posedge CLK); #1;
        RESET = 1'b0;
        model_reinit();
        for (int i = 0; i < 5; i++) begin
            drive(2, 0, 0, 0, 0, pxof(ch[i]), pxof(cv[i]));
            checks++;
            if (COLOUR !== want[i]) begin
                errors++;
                $display("FAIL reset_render cell(%0d,%0d): got %h expected %h", ch[i], cv[i], COLOUR, want[i]);
            end
        end
    endtask

    task automatic test_move();
        int ch [4] = '{7, 3, 2, 8};
        logic [7:0] want [4] = '{8'hFF, 8'hFF, 8'h40, 8'h40};
        drive(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) drive(1, 1, 0, 0, 0, 0, 0);
        checks++;
        if (SNAKE_LEN !== 7'd5) begin
            errors++;
            $display("FAIL move_len: got %0d expected 5", SNAKE_LEN);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 0, 0, 0, pxof(ch[i]), pxof(0));
            checks++;
            if (COLOUR !== want[i]) begin
                errors++;
                $display("FAIL move_render cell(%0d,0): got %h expected %h", ch[i], COLOUR, want[i]);
            end
        end
        drive(1, 1, 3, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, pxof(8), pxof(0));
        checks++;
        if (COLOUR !== 8'hFF) begin
            errors++;
            $display("FAIL reversal_head: got %h expected ff", COLOUR);
        end
        drive(1, 0, 0, 0, 0, pxof(3), pxof(0));
        checks++;
        if (COLOUR !== 8'h40) begin
            errors++;
            $display("FAIL reversal_tail: got %h expected 40", COLOUR);
        end
    endtask

    task automatic test_eat_place();
        drive(0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 36; i++) drive(1, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 29; i++) drive(1, 1, 1, 0, 0, 0, 0);
        checks++;
        if (REACHED_TARGET !== 1'b0) begin
            errors++;
            $display("FAIL eat_early: got %b expected 0", REACHED_TARGET);
        end
        drive(1, 1, 1, 0, 0, 0, 0);
        checks++;
        if (REACHED_TARGET !== 1'b1 || SNAKE_LEN !== 7'd6) begin
            errors++;
            $display("FAIL eat_pulse: got rt=%b len=%0d expected rt=1 len=6", REACHED_TARGET, SNAKE_LEN);
        end
        drive(1, 1, 1, 100, 10, pxof(40), pxof(30));
        checks++;
        if (REACHED_TARGET !== 1'b0 || COLOUR !== 8'h07) begin
            errors++;
            $display("FAIL place_first: got rt=%b col=%h expected rt=0 col=07", REACHED_TARGET, COLOUR);
        end
        drive(1, 0, 0, 40, 27, pxof(20), pxof(20));
        checks++;
        if (COLOUR !== 8'h40) begin
            errors++;
            $display("FAIL place_reject: got %h expected 40", COLOUR);
        end
        drive(1, 0, 0, 20, 20, pxof(40), pxof(31));
        checks++;
        if (COLOUR !== 8'h40) begin
            errors++;
            $display("FAIL place_tick_dropped: got %h expected 40", COLOUR);
        end
        drive(1, 0, 0, 0, 0, pxof(20), pxof(20));
        checks++;
        if (COLOUR !== 8'h07) begin
            errors++;
            $display("FAIL place_apple: got %h expected 07", COLOUR);
        end
        drive(1, 1, 1, 0, 0, pxof(40), pxof(30));
        checks++;
        if (COLOUR !== 8'hFF) begin
            errors++;
            $display("FAIL place_head: got %h expected ff", COLOUR);
        end
        drive(1, 0, 0, 0, 0, pxof(40), pxof(31));
        checks++;
        if (COLOUR !== 8'hFF || SNAKE_LEN !== 7'd6) begin
            errors++;
            $display("FAIL after_place_move: got col=%h len=%0d expected col=ff len=6", COLOUR, SNAKE_LEN);
        end
    endtask

    task automatic test_collision();
        int  nav [3]  = '{1, 3, 2};
        bit  want [3] = '{1'b0, 1'b0, 1'b1};
        int  ch [4]   = '{3, 4, 2, 5};
        int  cv [4]   = '{1, 1, 0, 0};
        logic [7:0] wc [4] = '{8'hFF, 8'hFF, 8'hFF, 8'h40};
        drive(0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, nav[i], 0, 0, 0, 0);
            checks++;
            if (GAME_OVER !== want[i]) begin
                errors++;
                $display("FAIL collide_tick%0d: got %b expected %b", i, GAME_OVER, want[i]);
            end
        end
        drive(1, 1, 0, 0, 0, 0, 0);
        drive(1, 1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 0, 0, 0, pxof(ch[i]), pxof(cv[i]));
            checks++;
            if (COLOUR !== wc[i] || GAME_OVER !== 1'b1 || SNAKE_LEN !== 7'd5) begin
                errors++;
                $display("FAIL frozen cell(%0d,%0d): got col=%h go=%b len=%0d expected col=%h go=1 len=5",
                         ch[i], cv[i], COLOUR, GAME_OVER, SNAKE_LEN, wc[i]);
            end
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (GAME_OVER !== 1'b0) begin
            errors++;
            $display("FAIL dead_reinit: got %b expected 0", GAME_OVER);
        end
    endtask

    task automatic test_wall();
        drive(0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 75; i++) drive(1, 1, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, pxof(79), pxof(0));
        checks++;
        if (COLOUR !== 8'hFF || GAME_OVER !== 1'b0) begin
            errors++;
            $display("FAIL wall_edge: got col=%h go=%b expected col=ff go=0", COLOUR, GAME_OVER);
        end
        drive(1, 1, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, pxof(0), pxof(0));
`ifdef SNAKE_WRAP_EN
        checks++;
        if (GAME_OVER !== 1'b0 || COLOUR !== 8'hFF) begin
            errors++;
            $display("FAIL wall_wrap: got go=%b col=%h expected go=0 col=ff", GAME_OVER, COLOUR);
        end
`else
        checks++;
        if (GAME_OVER !== 1'b1 || COLOUR !== 8'h40) begin
            errors++;
            $display("FAIL wall_hit: got go=%b col=%h expected go=1 col=40", GAME_OVER, COLOUR);
        end
`endif
    endtask

    task automatic test_random();
        int ms, nav, rh, rv, px, py, k;
        bit tick;
        drive(0, 0, 0, 0, 0, 0, 0);
        for (int cyc = 0; cyc < 4000; cyc++) begin
            ms = 1;
            if (m_dead && $urandom_range(0, 9) < 3) ms = 0;
            else if (!m_placing && $urandom_range(0, 99) < 5) ms = 2 + int'($urandom_range(0, 1));
            else if ($urandom_range(0, 199) == 0) ms = 0;
            tick = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 9) < 7) begin
                if (m_ah > mh[0]) nav = 0;
                else if (m_ah < mh[0]) nav = 3;
                else if (m_av > mv[0]) nav = 1;
                else nav = 2;
            end else begin
                nav = int'($urandom_range(0, 3));
            end
            k  = int'($urandom_range(0, mh.size() - 1));
            rh = int'($urandom_range(0, (1 << H_BITS) - 1));
            rv = int'($urandom_range(0, (1 << V_BITS) - 1));
            if ($urandom_range(0, 4) == 0) begin
                rh = mh[k];
                rv = mv[k];
            end
            if ($urandom_range(0, 1) == 1) begin
                px = pxof(mh[k]);
                py = pxof(mv[k]);
            end else begin
                px = int'($urandom_range(0, 1023));
                py = int'($urandom_range(0, 511));
            end
            drive(ms, tick, nav, rh, rv, px, py);
            checks++;
            if (COLOUR !== exp_col) begin
                errors++;
                $display("FAIL rand_colour cyc %0d: got %h expected %h", cyc, COLOUR, exp_col);
            end
            checks++;
            if (REACHED_TARGET !== m_reach) begin
                errors++;
                $display("FAIL rand_reached cyc %0d: got %b expected %b", cyc, REACHED_TARGET, m_reach);
            end
            checks++;
            if (GAME_OVER !== m_dead) begin
                errors++;
                $display("FAIL rand_game_over cyc %0d: got %b expected %b", cyc, GAME_OVER, m_dead);
            end
            checks++;
            if (SNAKE_LEN !== 7'(mh.size())) begin
                errors++;
                $display("FAIL rand_len cyc %0d: got %0d expected %0d", cyc, SNAKE_LEN, mh.size());
            end
            if ($urandom_range(0, 299) == 0) begin
                #2 RESET = 1'b1;
                #1;
                checks++;
                if (COLOUR !== 8'h00 || REACHED_TARGET !== 1'b0 || GAME_OVER !== 1'b0 || SNAKE_LEN !== 7'd5) begin
                    errors++;
                    $display("FAIL rand_async_reset cyc %0d: got col=%h rt=%b go=%b len=%0d expected 00/0/0/5",
                             cyc, COLOUR, REACHED_TARGET, GAME_OVER, SNAKE_LEN);
                end
                #1 RESET = 1'b0;
                model_reinit();
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        model_reinit();
        test_reset();
        test_move();
        test_eat_place();
        test_collision();
        test_wall();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
